// File: rtl/lut_func_recover.sv
// Reconstructs the 4-entry truth table of a 2-input logical unit from observed (a, b, out) samples.
// Locks once every entry has enough consistent samples, and latches the first contradiction.
module lut_func_recover #(
    parameter int HIT_W    = 4,
    parameter int MIN_HITS = 2,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 a,
    input  logic                 b,
    input  logic                 out_bit,
    output logic [3:0]           func,
    output logic [3:0]           seen,
    output logic                 func_valid,
    output logic                 conflict,
    output logic [1:0]           conflict_idx,
    output logic [CNT_W-1:0]     sample_count,
    output logic [1:0]           dbg_state,
    output logic [4*HIT_W-1:0]   dbg_hits
);
    // Handshake: a sample transfers on a rising edge where sample_valid and sample_ready
    // are both high and clear is low; sample_ready depends on state only.
    localparam logic [1:0]       ST_COLLECT = 2'd0;
    localparam logic [1:0]       ST_LOCKED  = 2'd1;
    localparam logic [1:0]       ST_ERROR   = 2'd2;
    localparam logic [HIT_W-1:0] HIT_MAX    = '1;
    localparam logic [HIT_W-1:0] HIT_MIN    = HIT_W'(MIN_HITS);

    logic [1:0]                r_state;
    logic [3:0]                r_func;
    logic [3:0]                r_seen;
    logic [3:0][HIT_W-1:0]     r_hits;
    logic                      r_func_valid;
    logic                      r_conflict;
    logic [1:0]                r_conflict_idx;
    logic [CNT_W-1:0]          r_count;

    logic [1:0]                w_idx;
    logic                      w_accept;
    logic                      w_mismatch;
    logic                      w_all_hit;
    logic [3:0][HIT_W-1:0]     w_hits_nxt;

    assign w_idx        = {a, b};
    assign sample_ready = (r_state != ST_ERROR);
    assign w_accept     = sample_valid & sample_ready & ~clear;
    assign w_mismatch   = w_accept & r_seen[w_idx] & (out_bit != r_func[w_idx]);

    // Look-ahead hit counts so the lock decision lands on the completing sample's edge.
    always_comb begin
        w_hits_nxt = r_hits;
        if (w_accept && !w_mismatch) begin
            if (!r_seen[w_idx])
                w_hits_nxt[w_idx] = HIT_W'(1);
            else if (r_hits[w_idx] != HIT_MAX)
                w_hits_nxt[w_idx] = r_hits[w_idx] + HIT_W'(1);
        end
        w_all_hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_hits_nxt[i] < HIT_MIN)
                w_all_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_COLLECT;
            r_func         <= '0;
            r_seen         <= '0;
            r_hits         <= '0;
            r_func_valid   <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_count        <= '0;
        end else if (clear) begin
            r_state        <= ST_COLLECT;
            r_func         <= '0;
            r_seen         <= '0;
            r_hits         <= '0;
            r_func_valid   <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_count        <= '0;
        end else if (w_accept) begin
            if (r_count != '1)
                r_count <= r_count + CNT_W'(1);
            r_hits <= w_hits_nxt;
            if (!r_seen[w_idx]) begin
                r_func[w_idx] <= out_bit;
                r_seen[w_idx] <= 1'b1;
            end
            // ERROR accepts nothing, so the first contradiction is never overwritten.
            if (w_mismatch) begin
                r_conflict     <= 1'b1;
                r_conflict_idx <= w_idx;
                r_state        <= ST_ERROR;
                r_func_valid   <= 1'b0;
            end else if (r_state == ST_COLLECT && w_all_hit) begin
                r_state      <= ST_LOCKED;
                r_func_valid <= 1'b1;
            end
        end
    end

    assign func         = r_func;
    assign seen         = r_seen;
    assign func_valid   = r_func_valid;
    assign conflict     = r_conflict;
    assign conflict_idx = r_conflict_idx;
    assign sample_count = r_count;
    assign dbg_state    = r_state;
    assign dbg_hits     = r_hits;

endmodule

// File: tb/tb_lut_func_recover.sv
// Directed bench for lut_func_recover: a driver pushes hand-computed expected snapshots,
// a monitor pops and compares them just after each rising edge.
module tb_lut_func_recover;
    localparam int W = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic v = 1'b0;
    logic v6 = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic o = 1'b0;

    logic        rdy, fv, cf;
    logic [3:0]  fn, sn;
    logic [1:0]  ci, st;
    logic [7:0]  cnt;
    logic [15:0] hits;

    logic        rdy6, fv6, cf6;
    logic [3:0]  fn6, sn6;
    logic [1:0]  ci6, st6;
    logic [3:0]  cnt6;
    logic [15:0] hits6;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    lut_func_recover #(.HIT_W(4), .MIN_HITS(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(v), .sample_ready(rdy),
        .a(a), .b(b), .out_bit(o), .func(fn), .seen(sn), .func_valid(fv),
        .conflict(cf), .conflict_idx(ci), .sample_count(cnt),
        .dbg_state(st), .dbg_hits(hits)
    );

    lut_func_recover #(.HIT_W(4), .MIN_HITS(2), .CNT_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(v6), .sample_ready(rdy6),
        .a(a), .b(b), .out_bit(o), .func(fn6), .seen(sn6), .func_valid(fv6),
        .conflict(cf6), .conflict_idx(ci6), .sample_count(cnt6),
        .dbg_state(st6), .dbg_hits(hits6)
    );

    function automatic logic [W-1:0] mk(input logic s, input logic [3:0] f, input logic [3:0] sd,
                                        input logic fvv, input logic c, input logic [1:0] cx,
                                        input logic [7:0] n, input logic r, input logic [1:0] q,
                                        input logic [15:0] h);
        return {s, f, sd, fvv, c, cx, n, r, q, h};
    endfunction

    function automatic logic [W-1:0] act(input logic s);
        if (s)
            return {1'b1, fn6, sn6, fv6, cf6, ci6, {4'b0, cnt6}, rdy6, st6, hits6};
        return {1'b0, fn, sn, fv, cf, ci, cnt, rdy, st, hits};
    endfunction

    task automatic compare(input string nm, input logic [W-1:0] e);
        logic [W-1:0] got;
        got = act(e[W-1]);
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (sel,func,seen,fv,conf,cidx,cnt,rdy,state,hits)",
                     nm, got, e);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0)
            compare(name_q.pop_front(), exp_q.pop_front());
    end

    task automatic step(input string nm, input logic vv, input logic vv6, input logic ai,
                        input logic bi, input logic oi, input logic cl, input logic [W-1:0] e);
        @(negedge clk);
        v = vv; v6 = vv6; a = ai; b = bi; o = oi; clear = cl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_test1(input int n);
        if (n >= 1) step("t1_s1", 1, 0, 0, 0, 1, 0, mk(0, 4'b0001, 4'b0001, 0, 0, 0, 1, 1, 0, 16'h0001));
        if (n >= 2) step("t1_s2", 1, 0, 0, 1, 0, 0, mk(0, 4'b0001, 4'b0011, 0, 0, 0, 2, 1, 0, 16'h0011));
        if (n >= 3) step("t1_s3", 1, 0, 1, 0, 0, 0, mk(0, 4'b0001, 4'b0111, 0, 0, 0, 3, 1, 0, 16'h0111));
        if (n >= 4) step("t1_s4", 1, 0, 1, 1, 1, 0, mk(0, 4'b1001, 4'b1111, 0, 0, 0, 4, 1, 0, 16'h1111));
        if (n >= 5) step("t1_s5", 1, 0, 0, 0, 1, 0, mk(0, 4'b1001, 4'b1111, 0, 0, 0, 5, 1, 0, 16'h1112));
        if (n >= 6) step("t1_s6", 1, 0, 0, 1, 0, 0, mk(0, 4'b1001, 4'b1111, 0, 0, 0, 6, 1, 0, 16'h1122));
        if (n >= 7) step("t1_s7", 1, 0, 1, 0, 0, 0, mk(0, 4'b1001, 4'b1111, 0, 0, 0, 7, 1, 0, 16'h1222));
        if (n >= 8) step("t1_lock", 1, 0, 1, 1, 1, 0, mk(0, 4'b1001, 4'b1111, 1, 0, 0, 8, 1, 1, 16'h2222));
    endtask

    localparam logic [W-1:0] ZERO0 = {1'b0, 39'b0} | W'(1) << 18;

    initial begin
        logic [7:0] k15;
        repeat (2) @(negedge clk);
        compare("reset_hold", ZERO0);
        rst_n = 1'b1;
        step("reset_release", 0, 0, 0, 0, 0, 0, ZERO0);

        // Lock, then contradict entry 1 while LOCKED.
        run_test1(8);
        step("t3_conflict", 1, 0, 0, 1, 1, 0, mk(0, 4'b1001, 4'b1111, 0, 1, 2'b01, 9, 0, 2, 16'h2222));
        step("t3_ignored", 1, 0, 0, 0, 0, 0, mk(0, 4'b1001, 4'b1111, 0, 1, 2'b01, 9, 0, 2, 16'h2222));
        step("t3_hold", 0, 0, 0, 0, 0, 0, mk(0, 4'b1001, 4'b1111, 0, 1, 2'b01, 9, 0, 2, 16'h2222));

        // clear wins over a simultaneous sample.
        step("t4_clear", 1, 0, 0, 0, 1, 1, ZERO0);
        step("t4_after", 0, 0, 0, 0, 0, 0, ZERO0);

        // Contradiction while still collecting.
        step("t2_first", 1, 0, 1, 0, 1, 0, mk(0, 4'b0100, 4'b0100, 0, 0, 0, 1, 1, 0, 16'h0100));
        step("t2_conflict", 1, 0, 1, 0, 0, 0, mk(0, 4'b0100, 4'b0100, 0, 1, 2'b10, 2, 0, 2, 16'h0100));
        step("t2_ignored", 1, 0, 0, 0, 0, 0, mk(0, 4'b0100, 4'b0100, 0, 1, 2'b10, 2, 0, 2, 16'h0100));
        step("t2_clear", 0, 0, 0, 0, 0, 1, ZERO0);

        // Asynchronous reset between edges, in the middle of a collection run.
        run_test1(3);
        @(posedge clk);
        #3;
        v = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
        #1;
        compare("t5_async_reset", ZERO0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("t5_after_release", 0, 0, 0, 0, 0, 0, ZERO0);
        run_test1(8);
        step("t5_locked_hold", 0, 0, 0, 0, 0, 0, mk(0, 4'b1001, 4'b1111, 1, 0, 0, 8, 1, 1, 16'h2222));
        step("t6_clear", 0, 0, 0, 0, 0, 1, ZERO0);

        // Saturation on the CNT_W=4 instance: 20 samples of (0,0,1).
        for (int i = 1; i <= 20; i++) begin
            k15 = (i > 15) ? 8'd15 : 8'(i);
            step("t6_sat", 0, 1, 0, 0, 1, 0,
                 mk(1, 4'b0001, 4'b0001, 0, 0, 0, k15, 1, 0, {12'h000, k15[3:0]}));
        end
        step("t6_hold", 0, 0, 0, 0, 0, 0, mk(1, 4'b0001, 4'b0001, 0, 0, 0, 15, 1, 0, 16'h000F));

        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
